pmod_bcd_converter: RTL

Sequential binary-to-BCD converter feeding the PMOD two-digit 7-segment display stage. It accepts a binary value and converts it to two decimal digits with a shift-and-add-3 (double-dabble) engine. The digits drive the display's `numa` (tens) and `numb` (ones) inputs. Outputs are held stable between conversions, so the display multiplexer always sees a consistent digit pair.

---
 rtl/pmod_pkg.sv | 6 +
 rtl/pmod_bcd_converter_if.sv | 22 ++
 rtl/bcd_add3.sv | 7 +
 rtl/pmod_bcd_converter.sv | 97 +++++++++
 4 files changed

// File: rtl/pmod_pkg.sv
// Shared types and constants for the PMOD binary-to-BCD converter.
package pmod_pkg;
   typedef enum logic {IDLE, CONV} state_t;
   localparam int         BCD_MAX       = 99;
   localparam logic [3:0] BCD_SAT_DIGIT = 4'd9;
endpackage

// File: rtl/pmod_bcd_converter_if.sv
// Request/result bundle between a converter client (master) and the converter (slave).
interface pmod_bcd_converter_if #(
   parameter int IN_WIDTH = 7
);
   logic                start;
   logic [IN_WIDTH-1:0] value;
   logic                ready;
   logic                done;
   logic [3:0]          numa;
   logic [3:0]          numb;
   logic                ovf;
   logic                blank_tens;

   modport master (
      output start, value,
      input  ready, done, numa, numb, ovf, blank_tens
   );
   modport slave (
      input  start, value,
      output ready, done, numa, numb, ovf, blank_tens
   );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to any digit of 5 or more before the shift.
module bcd_add3 (
   input  logic [3:0] in,
   output logic [3:0] out
);
   assign out = (in >= 4'd5) ? in + 4'd3 : in;
endmodule

// File: rtl/pmod_bcd_converter.sv
// Sequential shift-and-add-3 converter producing a two-digit BCD pair for the PMOD display,
// saturating to 99 for inputs above the two-digit range.
module pmod_bcd_converter
   import pmod_pkg::*;
#(
   parameter int IN_WIDTH = 7
) (
   input  logic                     clk,
   input  logic                     rst,
   pmod_bcd_converter_if.slave      bus
);
   localparam int CNT_W = $clog2(IN_WIDTH);

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg;
   logic [IN_WIDTH-1:0] bin_reg;
   logic [3:0]          digit_reg [2];
   logic [3:0]          digit_adj [2];
   logic                pend_ovf_reg;
   logic [3:0]          numa_reg, numb_reg;
   logic                ovf_reg, blank_reg, done_reg;

   logic                accept, last_iter, sat;
   logic [3:0]          tens_next, ones_next, numa_next, numb_next;

   // Index 0 is the ones digit, index 1 the tens digit.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_add3
         bcd_add3 u_add3 (
            .in  (digit_reg[gi]),
            .out (digit_adj[gi])
         );
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      accept     = bus.start && (state_reg == IDLE);
      last_iter  = (state_reg == CONV) && (cnt_reg == CNT_W'(IN_WIDTH - 1));
      tens_next  = {digit_adj[1][2:0], digit_adj[0][3]};
      ones_next  = {digit_adj[0][2:0], bin_reg[IN_WIDTH-1]};
      // A bit shifted out of the tens nibble can only happen for inputs above 99.
      sat        = pend_ovf_reg || digit_adj[1][3];
      numa_next  = sat ? BCD_SAT_DIGIT : tens_next;
      numb_next  = sat ? BCD_SAT_DIGIT : ones_next;
      case (state_reg)
         IDLE:    if (accept)    state_next = CONV;
         CONV:    if (last_iter) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         bin_reg      <= '0;
         digit_reg[0] <= 4'd0;
         digit_reg[1] <= 4'd0;
         pend_ovf_reg <= 1'b0;
         numa_reg     <= 4'd0;
         numb_reg     <= 4'd0;
         ovf_reg      <= 1'b0;
         blank_reg    <= 1'b1;
         done_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= last_iter;
         if (accept) begin
            bin_reg      <= bus.value;
            digit_reg[0] <= 4'd0;
            digit_reg[1] <= 4'd0;
            cnt_reg      <= '0;
            pend_ovf_reg <= (32'(bus.value) > BCD_MAX);
         end else if (state_reg == CONV) begin
            digit_reg[0] <= ones_next;
            digit_reg[1] <= tens_next;
            bin_reg      <= bin_reg << 1;
            cnt_reg      <= cnt_reg + 1'b1;
            pend_ovf_reg <= sat;
            if (last_iter) begin
               numa_reg  <= numa_next;
               numb_reg  <= numb_next;
               ovf_reg   <= sat;
               blank_reg <= (numa_next == 4'd0) && !sat;
            end
         end
      end
   end

   assign bus.ready      = (state_reg == IDLE);
   assign bus.done       = done_reg;
   assign bus.numa       = numa_reg;
   assign bus.numb       = numb_reg;
   assign bus.ovf        = ovf_reg;
   assign bus.blank_tens = blank_reg;
endmodule
